b2c_req_initiator: RTL and testbench

- Initiator (source) end of the req_ack link that feeds blockC's b2C port.
- Accepts commands from an upstream rdy_vld stream and buffers them in a small FIFO.
- Issues each command as one req_ack transaction, waits for ack with a bounded timeout, then returns the ack payload (or an error) on a downstream rdy_vld response stream.

---
 rtl/b2c_req_initiator_if.sv | 29 ++
 rtl/b2c_req_initiator.sv | 150 +++++++++++++++
 tb/tb_b2c_req_initiator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/b2c_req_initiator_if.sv
// Signal bundle for the b2C initiator: upstream command stream, req_ack link
// and downstream response stream.
interface b2c_req_initiator_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RSP_W  = 16
);
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic              ack;
    logic [RSP_W-1:0]  ack_data;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [RSP_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              stray_ack;

    modport master (
        input  in_vld, in_data, ack, ack_data, rsp_rdy,
        output in_rdy, req, req_data, rsp_vld, rsp_data, rsp_err, stray_ack
    );

    modport slave (
        output in_vld, in_data, ack, ack_data, rsp_rdy,
        input  in_rdy, req, req_data, rsp_vld, rsp_data, rsp_err, stray_ack
    );
endinterface

// File: rtl/b2c_req_initiator.sv
// Initiator end of the req_ack link into blockC's b2C port: buffers commands,
// issues one req per command with an ack timeout, returns ack payload or error.
module b2c_req_initiator #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RSP_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    b2c_req_initiator_if.master bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;

    logic [CNT_W-1:0]  cnt;
    logic              start, done_ack, done_to, rsp_take;

    logic              req_q, rsp_vld_q, rsp_err_q, stray_q;
    logic [DATA_W-1:0] req_data_q;
    logic [RSP_W-1:0]  rsp_data_q;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.in_vld && !full;
    assign pop   = done_ack || done_to;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack is tested before the timeout so an ack in the last allowed cycle wins.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    state_nxt = RSP;
                    done_ack  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RSP;
                    done_to   = 1'b1;
                end
            end
            RSP: begin
                if (bus.rsp_rdy) begin
                    state_nxt = IDLE;
                    rsp_take  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt        <= '0;
            req_q      <= 1'b0;
            req_data_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            if (start) begin
                req_q      <= 1'b1;
                req_data_q <= head;
                cnt        <= '0;
            end else if (state == REQ && !pop) begin
                cnt <= cnt + 1'b1;
            end
            if (done_ack) begin
                req_q      <= 1'b0;
                rsp_vld_q  <= 1'b1;
                rsp_data_q <= bus.ack_data;
                rsp_err_q  <= 1'b0;
            end
            if (done_to) begin
                req_q      <= 1'b0;
                rsp_vld_q  <= 1'b1;
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
            if (rsp_take) begin
                rsp_vld_q <= 1'b0;
            end
            if (bus.ack && state != REQ) begin
                stray_q <= 1'b1;
            end
        end
    end

    assign bus.in_rdy    = !full;
    assign bus.req       = req_q;
    assign bus.req_data  = req_data_q;
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.stray_ack = stray_q;
endmodule

// File: tb/tb_b2c_req_initiator.sv
// Bench for b2c_req_initiator: directed scenarios then random traffic, all
// checked every cycle against a transaction-level model of the link.
module tb_b2c_req_initiator;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RSP_W  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TMO    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    b2c_req_initiator_if #(.DATA_W(DATA_W), .RSP_W(RSP_W)) bus ();

    b2c_req_initiator #(
        .DATA_W(DATA_W),
        .RSP_W(RSP_W),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Model: queue of accepted commands (head is the one in flight until it
    // completes), phase 0 idle / 1 request outstanding / 2 response offered.
    logic [DATA_W-1:0] q[$];
    int                phase;
    int                age;
    logic [DATA_W-1:0] m_reqdata;
    logic [RSP_W-1:0]  m_rdata;
    logic              m_rerr;
    logic              m_stray;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int req_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase     = 0;
        age       = 0;
        m_reqdata = '0;
        m_rdata   = '0;
        m_rerr    = 1'b0;
        m_stray   = 1'b0;
    endtask

    task automatic check_outputs();
        if (bus.req === 1'b1) req_hi++;
        chk("in_rdy",    bus.in_rdy,    q.size() < DEPTH);
        chk("req",       bus.req,       phase == 1);
        chk("req_data",  bus.req_data,  m_reqdata);
        chk("rsp_vld",   bus.rsp_vld,   phase == 2);
        chk("rsp_data",  bus.rsp_data,  m_rdata);
        chk("rsp_err",   bus.rsp_err,   m_rerr);
        chk("stray_ack", bus.stray_ack, m_stray);
    endtask

    // One clock: check current outputs, apply inputs, advance the model.
    task automatic cycle(input logic vld, input logic [DATA_W-1:0] d, input logic a,
                         input logic [RSP_W-1:0] ad, input logic rr, input logic rs);
        int  sz0;
        logic acc;
        check_outputs();
        rst_n        = rs;
        bus.in_vld   = vld;
        bus.in_data  = d;
        bus.ack      = a;
        bus.ack_data = ad;
        bus.rsp_rdy  = rr;
        if (rs) begin
            model_reset();
        end else begin
            sz0 = q.size();
            acc = vld && (sz0 < DEPTH);
            if (a && phase != 1) m_stray = 1'b1;
            case (phase)
                0: if (sz0 > 0) begin
                    phase = 1; age = 0; m_reqdata = q[0];
                end
                1: if (a) begin
                    m_rdata = ad; m_rerr = 1'b0; void'(q.pop_front()); phase = 2;
                end else if (age == TMO - 1) begin
                    m_rdata = '0; m_rerr = 1'b1; void'(q.pop_front()); phase = 2;
                end else begin
                    age++;
                end
                default: if (rr) phase = 0;
            endcase
            if (acc) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0 && phase == 0) break;
            cycle(1'b0, '0, (phase == 1) && ($urandom_range(0, 2) == 0),
                  RSP_W'($urandom), 1'b1, 1'b0);
        end
        chk("drain_idle", {bus.req, bus.rsp_vld}, 2'b00);
    endtask

    initial begin
        int k;
        logic acc;
        rst_n = 1'b1;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.ack = 1'b0;
        bus.ack_data = '0; bus.rsp_rdy = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        chk("rst_in_rdy", bus.in_rdy, 1'b1);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_rsp_vld", bus.rsp_vld, 1'b0);
        chk("rst_stray", bus.stray_ack, 1'b0);
        idle(2);

        // Single command, ack on the third req-high cycle.
        req_hi = 0;
        cycle(1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, '0, 1'b1, 16'h1234, 1'b1, 1'b0);
        chk("single_req_len", req_hi, 3);
        chk("single_rsp_vld", bus.rsp_vld, 1'b1);
        chk("single_rsp_data", bus.rsp_data, 16'h1234);
        chk("single_rsp_err", bus.rsp_err, 1'b0);
        chk("single_req_data", bus.req_data, 32'hDEADBEEF);
        idle(2);

        // Fill: five back-to-back pushes into a 4-deep FIFO with ack withheld.
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) chk("fill_full", bus.in_rdy, 1'b0);
            if (i == 7) chk("fill_after_pop", bus.in_rdy, 1'b1);
            acc = (k < 5) && (q.size() < DEPTH);
            cycle(k < 5, 32'hA0 + k, i == 6, 16'h0101, 1'b1, 1'b0);
            if (acc) k++;
        end
        chk("fill_all_pushed", k, 5);
        drain(200);

        // Timeout: no ack, then a second command served normally.
        req_hi = 0;
        cycle(1'b1, 32'h77770001, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h77770002, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 30 && phase != 2; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("to_rsp_vld", bus.rsp_vld, 1'b1);
        chk("to_req_len", req_hi, TMO);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_data", bus.rsp_data, 16'h0000);
        drain(100);

        // Ack in the last permitted cycle beats the timeout.
        req_hi = 0;
        cycle(1'b1, 32'h0000B0B0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 30 && phase != 2; i++)
            cycle(1'b0, '0, (phase == 1) && (age == TMO - 1), 16'hBEEF, 1'b1, 1'b0);
        chk("edge_req_len", req_hi, TMO);
        chk("edge_rsp_err", bus.rsp_err, 1'b0);
        chk("edge_rsp_data", bus.rsp_data, 16'hBEEF);

        // Backpressure for 10 cycles with a stray ack during RSP.
        for (int i = 0; i < 10; i++)
            cycle(i == 0, 32'h0000C0C0, i == 3, 16'hFFFF, 1'b0, 1'b0);
        chk("bp_rsp_vld", bus.rsp_vld, 1'b1);
        chk("bp_req", bus.req, 1'b0);
        chk("bp_rsp_data", bus.rsp_data, 16'hBEEF);
        chk("bp_stray", bus.stray_ack, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("bp_next_req", bus.req, 1'b1);
        chk("bp_next_data", bus.req_data, 32'h0000C0C0);
        drain(100);
        chk("bp_stray_sticky", bus.stray_ack, 1'b1);

        // Reset while a request is outstanding with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h50 + i, 1'b0, '0, 1'b1, 1'b0);
        chk("mid_req_high", bus.req, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        rst_n = 1'b0;
        chk("mid_rst_req", bus.req, 1'b0);
        chk("mid_rst_rsp_vld", bus.rsp_vld, 1'b0);
        chk("mid_rst_in_rdy", bus.in_rdy, 1'b1);
        chk("mid_rst_stray", bus.stray_ack, 1'b0);
        idle(5);

        // Random traffic with backpressure, stray acks and occasional resets.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom,
                  (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
                  RSP_W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end
        rst_n = 1'b0;
        drain(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
